// File: rtl/ap3_ram_pkg.sv
// AP3 RAM macro port widths, width-mode encodings and a FIFO depth helper.
package ap3_ram_pkg;
  localparam int RAM_AW = 11;
  localparam int RAM_DW = 32;

  typedef enum logic [1:0] {
    MODE_X32 = 2'b00,
    MODE_X16 = 2'b01,
    MODE_X8  = 2'b10
  } ram_mode_t;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/ram_fifo_out_stage.sv
// Two-entry FWFT skid buffer (head + skid): captured word is visible on head the next cycle.
// Never refuses a write; the caller keeps occupancy plus reads in flight at or below two.
module ram_fifo_out_stage
  import ap3_ram_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);
  logic [DATA_W-1:0] skid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      skid <= '0;
      occ  <= 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (wr_en) begin
            head <= wr_data;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          case ({wr_en, rd_en})
            2'b10: begin
              skid <= wr_data;
              occ  <= 2'd2;
            end
            2'b11:   head <= wr_data;
            2'b01:   occ  <= 2'd0;
            default: ;
          endcase
        end
        default: begin
          // Full: a pop promotes the skid word; a simultaneous capture refills skid.
          if (rd_en) begin
            head <= skid;
            if (wr_en) skid <= wr_data;
            else       occ  <= 2'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// Soft FIFO controller over the AP3 RAM in plain RAM mode with a FWFT output stage.
// Push-to-out_valid latency 3 cycles; in_ready = ~full, pushes while full are dropped and flagged.
module ram_fifo_ctrl
  import ap3_ram_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int AF_LEVEL = 500,
  parameter int AE_LEVEL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDR_W+1:0]   total_count,
  output logic                overflow,
  output logic [RAM_AW-1:0]   ram_waddr,
  output logic [RAM_DW-1:0]   ram_wdata,
  output logic                ram_wen,
  output logic [RAM_AW-1:0]   ram_raddr,
  output logic                ram_ren,
  input  logic [RAM_DW-1:0]   ram_rdata
);
  localparam int DEPTH = fifo_depth(ADDR_W);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   ram_count, ram_count_nxt;
  logic              inflight, full, wr_acc, pop;
  logic [1:0]        out_occ;
  logic [2:0]        out_occ_nxt;
  logic [ADDR_W+1:0] total_nxt;

  assign full     = (ram_count == (ADDR_W+1)'(DEPTH));
  assign in_ready = ~full;
  assign wr_acc   = in_valid & ~full & ~rst;
  assign pop      = out_valid & out_ready;

  // Output-stage occupancy after this cycle's capture and pop; a new read may
  // only issue if its word will still have a slot when it lands.
  assign out_occ_nxt = {1'b0, out_occ} + {2'b00, inflight} - {2'b00, pop};
  assign ram_ren     = ~rst & (ram_count != '0) & (out_occ_nxt < 3'd2);

  assign ram_wen   = wr_acc;
  assign ram_waddr = RAM_AW'(wptr);
  assign ram_wdata = RAM_DW'(in_data);
  assign ram_raddr = RAM_AW'(rptr);

  assign ram_count_nxt = ram_count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(ram_ren);
  assign total_nxt     = (ADDR_W+2)'(ram_count_nxt) + (ADDR_W+2)'(ram_ren)
                       + (ADDR_W+2)'(out_occ_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      ram_count    <= '0;
      inflight     <= 1'b0;
      overflow     <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      total_count  <= '0;
    end else begin
      if (wr_acc)  wptr <= wptr + 1'b1;
      if (ram_ren) rptr <= rptr + 1'b1;
      ram_count    <= ram_count_nxt;
      inflight     <= ram_ren;
      overflow     <= in_valid & full;
      almost_full  <= (ram_count_nxt >= (ADDR_W+1)'(AF_LEVEL));
      almost_empty <= (total_nxt <= (ADDR_W+2)'(AE_LEVEL));
      total_count  <= total_nxt;
    end
  end

  ram_fifo_out_stage #(.DATA_W(DATA_W)) u_out_stage (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (ram_rdata[DATA_W-1:0]),
    .rd_en   (pop),
    .head    (out_data),
    .occ     (out_occ)
  );

  assign out_valid = (out_occ != 2'd0);
endmodule
